// File: rtl/ps2_keyboard_controller_if.sv
// CPU-side keyboard register bus: word-addressed reads with one-cycle latency,
// byte-enable writes, plus the level interrupt.
interface ps2_keyboard_controller_if;
  logic [31:0] cpu_addr_in;
  logic [31:0] cpu_data_in;
  logic [3:0]  cpu_write_enable_in;
  logic [31:0] cpu_data_out;
  logic        irq_out;

  modport master (
    output cpu_addr_in,
    output cpu_data_in,
    output cpu_write_enable_in,
    input  cpu_data_out,
    input  irq_out
  );

  modport slave (
    input  cpu_addr_in,
    input  cpu_data_in,
    input  cpu_write_enable_in,
    output cpu_data_out,
    output irq_out
  );
endinterface

// File: rtl/ps2_keyboard_controller.sv
// PS/2 device-to-host frame receiver with a scancode FIFO and
// memory-mapped DATA / STATUS / ERRORS registers.
//
// state    | meaning
// S_IDLE   | waiting for a start bit (data low on a falling edge)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | sampling the odd-parity bit
// S_STOP   | sampling the stop bit, then push or count an error
module ps2_keyboard_controller #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     ps2_clk_in,
  input  logic                     ps2_data_in,
  ps2_keyboard_controller_if.slave cpu
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t state, state_nxt;

  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic fall;

  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic          par_ok;
  logic [TW-1:0] idle_cnt;
  logic          timeout;

  logic push, par_inc, frm_inc;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full;
  logic          overflow;
  logic [7:0]    parity_err, frame_err;
  logic [7:0]    head;
  logic [7:0]    count_byte;

  logic        cpu_we;
  logic [1:0]  idx;
  logic        do_pop, do_push, ovf_set;
  logic [31:0] rdata;
  logic        unused_bits;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data_in;
      dat_s2   <= dat_s1;
    end
  end

  assign fall    = clk_prev & ~clk_s2;
  assign par_ok  = ^{shift, par_bit};
  assign timeout = (state != S_IDLE) && (idle_cnt == '0) && !fall;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!dat_s2) state_nxt = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    push    = 1'b0;
    par_inc = 1'b0;
    frm_inc = 1'b0;
    if (timeout) begin
      frm_inc = 1'b1;
    end else if (fall && state == S_STOP) begin
      if (dat_s2 && par_ok) push    = 1'b1;
      else if (!par_ok)     par_inc = 1'b1;
      else                  frm_inc = 1'b1;
    end
  end

  // Idle timer runs down from the last falling edge; zero mid-frame aborts.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      shift    <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      idle_cnt <= TIMEOUT_LOAD;
    end else begin
      if (fall || state == S_IDLE) idle_cnt <= TIMEOUT_LOAD;
      else if (idle_cnt != '0)     idle_cnt <= idle_cnt - TW'(1);

      if (timeout) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (fall) begin
        case (state)
          S_IDLE:   bit_cnt <= '0;
          S_DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_PARITY: par_bit <= dat_s2;
          default:  ;
        endcase
      end
    end
  end

  assign cpu_we     = |cpu.cpu_write_enable_in;
  assign idx        = cpu.cpu_addr_in[3:2];
  assign empty      = (count == '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign do_pop     = cpu_we && idx == 2'd0 && !empty;
  assign do_push    = push && (!full || do_pop);
  assign ovf_set    = push && full && !do_pop;
  assign head       = empty ? 8'h00 : mem[rd_ptr];
  assign count_byte = 8'(count);

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      parity_err <= '0;
      frame_err  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      if (ovf_set) overflow <= 1'b1;
      else if (cpu_we && idx == 2'd1 && cpu.cpu_data_in[1]) overflow <= 1'b0;

      // A clear beats a same-cycle increment.
      if (cpu_we && idx == 2'd2) begin
        parity_err <= '0;
        frame_err  <= '0;
      end else begin
        if (par_inc && parity_err != 8'hFF) parity_err <= parity_err + 8'd1;
        if (frm_inc && frame_err != 8'hFF)  frame_err  <= frame_err + 8'd1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      2'd0:    rdata = {23'b0, ~empty, head};
      2'd1:    rdata = {22'b0, count_byte, overflow, empty};
      2'd2:    rdata = {16'b0, parity_err, frame_err};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cpu.cpu_data_out <= '0;
      cpu.irq_out      <= 1'b0;
    end else begin
      cpu.cpu_data_out <= rdata;
      cpu.irq_out      <= ~empty;
    end
  end

  assign unused_bits = ^{cpu.cpu_addr_in[31:4], cpu.cpu_addr_in[1:0],
                         cpu.cpu_data_in[31:2], cpu.cpu_data_in[0]};
endmodule

// File: tb/tb_ps2_keyboard_controller.sv
// Directed PS/2 frames and CPU register accesses; a monitor checks every
// registered read against the expected-response queue.
module tb_ps2_keyboard_controller;
  localparam int TOUT = 500;
  localparam int HALF = 40;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_keyboard_controller_if bus();

  ps2_keyboard_controller #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .ps2_clk_in  (ps2_clk),
    .ps2_data_in (ps2_data),
    .cpu         (bus)
  );

  always #10 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  string       exp_name[$];
  logic [31:0] exp_data[$];
  int          exp_irq[$];

  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  always @(posedge clk_in) rd_vld <= rd_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (rd_vld) begin
      if (exp_data.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", bus.cpu_data_out);
      end else begin
        string       n;
        logic [31:0] d;
        int          q;
        n = exp_name.pop_front();
        d = exp_data.pop_front();
        q = exp_irq.pop_front();
        check(n, bus.cpu_data_out, d);
        if (q >= 0) check({n, "_irq"}, {31'b0, bus.irq_out}, 32'(q));
      end
    end
  end

  task automatic cpu_read(input logic [1:0] idx, input logic [31:0] exp, input int irq,
                          input string name);
    @(negedge clk_in);
    bus.cpu_addr_in         = {28'h0, idx, 2'b00};
    bus.cpu_write_enable_in = 4'h0;
    rd_req                  = 1'b1;
    exp_name.push_back(name);
    exp_data.push_back(exp);
    exp_irq.push_back(irq);
    @(negedge clk_in);
    rd_req = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] idx, input logic [31:0] data);
    @(negedge clk_in);
    bus.cpu_addr_in         = {28'h0, idx, 2'b00};
    bus.cpu_data_in         = data;
    bus.cpu_write_enable_in = 4'hF;
    @(negedge clk_in);
    bus.cpu_write_enable_in = 4'h0;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic par_flip,
                                        input logic stop);
    return {stop, (~^d) ^ par_flip, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk_in);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk_in);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk_in);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    send_bits(frame(d, par_flip, stop), 11);
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cpu_addr_in         = '0;
    bus.cpu_data_in         = '0;
    bus.cpu_write_enable_in = '0;
    repeat (5) @(negedge clk_in);
    check("rst_data_out", bus.cpu_data_out, 32'h0);
    check("rst_irq", {31'b0, bus.irq_out}, 32'h0);
    rst_in = 1'b1;
    repeat (5) @(negedge clk_in);
    cpu_read(2'd1, 32'h0000_0001, 0, "init_status");
    cpu_read(2'd2, 32'h0000_0000, 0, "init_errors");

    // Good 0x1C frame, then pop it.
    send_frame(8'h1C, 1'b0, 1'b1);
    cpu_read(2'd1, 32'h0000_0004, 1, "good_status");
    cpu_read(2'd0, 32'h0000_011C, 1, "good_data");
    cpu_write(2'd0, 32'h0);
    cpu_read(2'd1, 32'h0000_0001, 0, "popped_status");
    cpu_read(2'd0, 32'h0000_0000, 0, "empty_data");

    // Parity error, then clear the counters.
    send_frame(8'h1C, 1'b1, 1'b1);
    cpu_read(2'd1, 32'h0000_0001, 0, "par_status");
    cpu_read(2'd2, 32'h0000_0100, -1, "par_errors");
    cpu_write(2'd2, 32'h0);
    cpu_read(2'd2, 32'h0000_0000, -1, "cleared_errors");

    // Stop-bit error.
    send_frame(8'hF0, 1'b0, 1'b0);
    cpu_read(2'd1, 32'h0000_0001, 0, "stop_status");
    cpu_read(2'd2, 32'h0000_0001, -1, "stop_errors");
    cpu_write(2'd2, 32'h0);

    // Fill past capacity to trigger overflow.
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b0, 1'b1);
    cpu_read(2'd1, 32'h0000_0042, 1, "full_status");
    cpu_read(2'd2, 32'h0000_0000, -1, "full_errors");
    cpu_write(2'd3, 32'hFFFF_FFFF);
    cpu_read(2'd1, 32'h0000_0042, 1, "reg3_write_ignored");
    cpu_read(2'd3, 32'h0000_0000, -1, "reg3_read");
    for (int i = 0; i < 16; i++) begin
      cpu_read(2'd0, 32'h0000_0100 | 32'(i), 1, $sformatf("pop_%0d", i));
      cpu_write(2'd0, 32'h0);
    end
    cpu_read(2'd1, 32'h0000_0003, 0, "drained_status");
    cpu_write(2'd1, 32'h0000_0002);
    cpu_read(2'd1, 32'h0000_0001, 0, "ovf_cleared_status");

    // Partial frame followed by a stalled PS/2 clock.
    send_bits(frame(8'h00, 1'b0, 1'b1), 5);
    repeat (TOUT + 50) @(negedge clk_in);
    cpu_read(2'd2, 32'h0000_0001, -1, "timeout_errors");
    cpu_read(2'd1, 32'h0000_0001, 0, "timeout_status");
    send_frame(8'hE0, 1'b0, 1'b1);
    cpu_read(2'd1, 32'h0000_0004, 1, "after_to_status");
    cpu_read(2'd0, 32'h0000_01E0, 1, "after_to_data");
    cpu_write(2'd0, 32'h0);
    cpu_read(2'd2, 32'h0000_0001, -1, "after_to_errors");

    // Reset in the middle of a frame, with a byte and an error pending.
    send_frame(8'h33, 1'b0, 1'b1);
    cpu_read(2'd1, 32'h0000_0004, 1, "pre_rst_status");
    send_bits(frame(8'hA5, 1'b0, 1'b1), 6);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("midrst_data_out", bus.cpu_data_out, 32'h0);
    check("midrst_irq", {31'b0, bus.irq_out}, 32'h0);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    cpu_read(2'd0, 32'h0000_0000, 0, "post_rst_data");
    cpu_read(2'd1, 32'h0000_0001, 0, "post_rst_status");
    cpu_read(2'd2, 32'h0000_0000, 0, "post_rst_errors");
    cpu_read(2'd3, 32'h0000_0000, 0, "post_rst_reg3");
    send_frame(8'h5A, 1'b0, 1'b1);
    cpu_read(2'd1, 32'h0000_0004, 1, "post_rst_good_status");
    cpu_read(2'd0, 32'h0000_015A, 1, "post_rst_good_data");
    cpu_read(2'd2, 32'h0000_0000, -1, "post_rst_good_errors");

    for (int k = 0; k < 100 && exp_data.size() > 0; k++) @(negedge clk_in);
    if (exp_data.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending reads expected 0", exp_data.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
